// File: rtl/i2c_cfg_master.sv
// i2c_cfg_master: walks a synchronous configuration table and writes each
// entry {reg_addr, data} to one I2C/SCCB slave over open-drain SCL/SDA.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start (or auto start)
// S_LOAD  | table read address stable, entry latched on 2nd cycle
// S_START | START condition: SDA falls with SCL high, then SCL falls
// S_SHIFT | 8 bits MSB first, SDA low for 0 / released for 1
// S_ACK   | SDA released, slave ACK sampled in phase 2
// S_STOP  | STOP condition: SDA low, SCL released, SDA released
// S_GAP   | bus idle for GAP_CYCLES, then retry / next entry / finish
// S_DONE  | table completed, done held
// S_ERROR | retries exhausted on err_index, error held
module i2c_cfg_master #(
    parameter int         CLK_DIV    = 125,
    parameter logic [6:0] DEV_ADDR   = 7'h39,
    parameter int         REG_BYTES  = 1,
    parameter int         DATA_BYTES = 1,
    parameter int         LUT_DEPTH  = 64,
    parameter int         RETRY_MAX  = 3,
    parameter int         GAP_CYCLES = 1000,
    parameter int         AUTO_START = 1,
    localparam int        IW         = $clog2(LUT_DEPTH),
    localparam int        EW         = 8 * (REG_BYTES + DATA_BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [IW-1:0] lut_index,
    input  logic [EW-1:0] lut_data,
    output logic          scl_oe,
    output logic          sda_oe,
    input  logic          sda_i,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [IW-1:0] err_index
);

    localparam int FB = 1 + REG_BYTES + DATA_BYTES;
    localparam int FW = 8 * FB;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_START, S_SHIFT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_cnt;
    logic [FW-1:0] sh;
    logic [EW-1:0] ent;
    logic [RW-1:0] retry;
    logic          nack;
    logic [GW-1:0] gap_cnt;
    logic          ld_cnt;
    logic          sda_m, sda_s;
    logic          bus_end;
    logic          last_byte;

    assign tick      = (div_cnt == '0);
    assign bus_end   = tick && (phase == 2'd3);
    assign last_byte = (byte_cnt == 3'(FB - 1));
    assign busy      = state inside {S_LOAD, S_START, S_SHIFT, S_ACK, S_STOP, S_GAP};

    // Free-running quarter-period divider; tick on terminal count zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= tick ? DW'(CLK_DIV - 1) : div_cnt - 1'b1;
    end

    // Two-flop synchronizer on the SDA pad; idle bus reads high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {sda_s, sda_m} <= 2'b11;
        else        {sda_s, sda_m} <= {sda_m, sda_i};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; bus states only leave on the phase-3 tick.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start || (AUTO_START != 0)) state_nxt = S_LOAD;
            S_LOAD:  if (ld_cnt) state_nxt = (&lut_data) ? S_DONE : S_START;
            S_START: if (bus_end) state_nxt = S_SHIFT;
            S_SHIFT: if (bus_end && (bit_cnt == 3'd7)) state_nxt = S_ACK;
            S_ACK:   if (bus_end) state_nxt = (nack || last_byte) ? S_STOP : S_SHIFT;
            S_STOP:  if (bus_end) state_nxt = S_GAP;
            S_GAP: begin
                if (gap_cnt == '0) begin
                    if (nack)
                        state_nxt = (retry < RW'(RETRY_MAX)) ? S_START : S_ERROR;
                    else if (lut_index == IW'(LUT_DEPTH - 1))
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_LOAD;
                end
            end
            S_DONE, S_ERROR: if (start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus drive, frame shifter, retry/gap bookkeeping and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            phase     <= 2'd0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 3'd0;
            sh        <= '0;
            ent       <= '0;
            retry     <= '0;
            nack      <= 1'b0;
            gap_cnt   <= '0;
            ld_cnt    <= 1'b0;
            lut_index <= '0;
            err_index <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= (state_nxt == S_DONE);
            error <= (state_nxt == S_ERROR);
            if (tick && (state inside {S_START, S_SHIFT, S_ACK, S_STOP}))
                phase <= phase + 2'd1;
            case (state)
                S_LOAD: begin
                    ld_cnt <= 1'b1;
                    if (ld_cnt) begin
                        ld_cnt <= 1'b0;
                        ent    <= lut_data;
                    end
                end
                S_START: if (tick) begin
                    case (phase)
                        2'd0: begin
                            scl_oe   <= 1'b0;
                            sda_oe   <= 1'b0;
                            sh       <= {DEV_ADDR, 1'b0, ent};
                            nack     <= 1'b0;
                            bit_cnt  <= 3'd0;
                            byte_cnt <= 3'd0;
                        end
                        2'd2:    sda_oe <= 1'b1;
                        default: scl_oe <= (phase == 2'd3) ? 1'b1 : scl_oe;
                    endcase
                end
                S_SHIFT: if (tick) begin
                    case (phase)
                        2'd0: sda_oe <= ~sh[FW-1];
                        2'd1: scl_oe <= 1'b0;
                        2'd3: begin
                            scl_oe  <= 1'b1;
                            sh      <= {sh[FW-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        default: ;
                    endcase
                end
                S_ACK: if (tick) begin
                    case (phase)
                        2'd0: sda_oe <= 1'b0;
                        2'd1: scl_oe <= 1'b0;
                        2'd2: if (sda_s) nack <= 1'b1;
                        default: begin
                            scl_oe   <= 1'b1;
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    endcase
                end
                S_STOP: if (tick) begin
                    case (phase)
                        2'd0: sda_oe <= 1'b1;
                        2'd1: scl_oe <= 1'b0;
                        2'd3: begin
                            sda_oe  <= 1'b0;
                            gap_cnt <= GW'(GAP_CYCLES - 1);
                        end
                        default: ;
                    endcase
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (nack) begin
                        if (retry < RW'(RETRY_MAX)) retry <= retry + 1'b1;
                        else                        err_index <= lut_index;
                    end else begin
                        // Wraps to zero only when leaving for DONE from the last slot.
                        retry     <= '0;
                        lut_index <= lut_index + 1'b1;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        lut_index <= '0;
                        err_index <= '0;
                        retry     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_master.sv
// Bench for i2c_cfg_master: two instances on one shared open-drain bus with
// a behavioural slave that records every received byte and can NACK.
module tb_i2c_cfg_master;

    logic        clk = 1'b0;
    logic        rst_n_a = 1'b0, rst_n_b = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  lut_index_a, lut_index_b, err_index_a, err_index_b;
    logic [15:0] lut_data_a = '0;
    logic [23:0] lut_data_b = '0;
    logic        scl_oe_a, sda_oe_a, busy_a, done_a, error_a;
    logic        scl_oe_b, sda_oe_b, busy_b, done_b, error_b;
    logic        scl, sda;
    logic        slv_drv = 1'b0;

    logic [15:0] rom_a [4];
    logic [23:0] rom_b [4];

    int checks = 0;
    int errors = 0;

    // Slave model state (written only by the slave process).
    logic        pscl = 1'b1, psda = 1'b1;
    logic        in_frame = 1'b0, ack_phase = 1'b0, nack_now = 1'b0;
    logic [7:0]  shr = '0;
    int          bitc = 0, byte_no = 0, frames = 0, stops = 0;
    int          hi_cnt = 0, hi_len = 0, obs_cnt = 0, data_nacks = 0;
    logic [7:0]  obs_mem [256];

    // Slave policy and scoreboard (written only by the stimulus process).
    int          nack_addr_thr = 1000000;
    int          nack_data_lim = 0;
    int          frame_target  = 0;
    int          rd = 0;
    int          base;
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    assign scl = ~(scl_oe_a | scl_oe_b);
    assign sda = ~(sda_oe_a | sda_oe_b | slv_drv);

    i2c_cfg_master #(.CLK_DIV(4), .DEV_ADDR(7'h39), .REG_BYTES(1), .DATA_BYTES(1),
                     .LUT_DEPTH(4), .RETRY_MAX(3), .GAP_CYCLES(20), .AUTO_START(1)) u_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .lut_index(lut_index_a),
        .lut_data(lut_data_a), .scl_oe(scl_oe_a), .sda_oe(sda_oe_a), .sda_i(sda),
        .busy(busy_a), .done(done_a), .error(error_a), .err_index(err_index_a));

    i2c_cfg_master #(.CLK_DIV(3), .DEV_ADDR(7'h39), .REG_BYTES(2), .DATA_BYTES(1),
                     .LUT_DEPTH(4), .RETRY_MAX(3), .GAP_CYCLES(10), .AUTO_START(0)) u_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .lut_index(lut_index_b),
        .lut_data(lut_data_b), .scl_oe(scl_oe_b), .sda_oe(sda_oe_b), .sda_i(sda),
        .busy(busy_b), .done(done_b), .error(error_b), .err_index(err_index_b));

    // Synchronous table ROMs: data valid one cycle after the index.
    always @(posedge clk) begin
        lut_data_a <= rom_a[lut_index_a];
        lut_data_b <= rom_b[lut_index_b];
    end

    // Behavioural slave: decodes START/STOP/bytes, ACKs per policy, times SCL high.
    always @(negedge clk) begin
        pscl <= scl;
        psda <= sda;
        if (scl && pscl)  hi_cnt <= hi_cnt + 1;
        else if (scl)     hi_cnt <= 1;
        if (!scl && pscl && in_frame) hi_len <= hi_cnt;
        if (scl && pscl && psda && !sda) begin
            in_frame  <= 1'b1;
            bitc      <= 0;
            byte_no   <= 0;
            ack_phase <= 1'b0;
            slv_drv   <= 1'b0;
            frames    <= frames + 1;
        end else if (scl && pscl && !psda && sda) begin
            in_frame <= 1'b0;
            stops    <= stops + 1;
        end else if (in_frame && scl && !pscl) begin
            if (bitc < 8) begin
                shr  <= {shr[6:0], sda};
                bitc <= bitc + 1;
                if (bitc == 7) begin
                    obs_mem[obs_cnt[7:0]] <= {shr[6:0], sda};
                    obs_cnt  <= obs_cnt + 1;
                    nack_now <= (byte_no == 0 && frames >= nack_addr_thr) ||
                                (byte_no == 2 && data_nacks < nack_data_lim);
                    if (byte_no == 2 && data_nacks < nack_data_lim)
                        data_nacks <= data_nacks + 1;
                end
            end
        end else if (in_frame && !scl && pscl && bitc == 8) begin
            if (!ack_phase) begin
                slv_drv   <= !nack_now;
                ack_phase <= 1'b1;
            end else begin
                slv_drv   <= 1'b0;
                ack_phase <= 1'b0;
                bitc      <= 0;
                byte_no   <= byte_no + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int n);
        logic [7:0] bs [4];
        bs = '{b0, b1, b2, b3};
        for (int i = 0; i < n; i++) exp_q.push_back(bs[i]);
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        chk({tag, "_bytes"}, 32'(obs_cnt - rd), 32'(exp_q.size()));
        while (rd < obs_cnt && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_byte"}, 32'(obs_mem[rd[7:0]]), 32'(e));
            rd++;
        end
        rd = obs_cnt;
        exp_q.delete();
    endtask

    task automatic wait_for(input int which, input int max, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(posedge clk); #1;
            case (which)
                0:       ok = done_a | error_a;
                1:       ok = done_b | error_b;
                2:       ok = in_frame && (bitc >= 4) && scl_oe_a && sda_oe_a;
                default: ok = (frames >= frame_target);
            endcase
        end
        chk({tag, "_wait"}, 32'(ok), 32'd1);
    endtask

    task automatic pulse_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic pulse_b();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
    endtask

    initial begin
        rom_a = '{16'h4110, 16'h9803, 16'hFFFF, 16'hFFFF};
        rom_b = '{24'h300A5A, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl_a", 32'(scl_oe_a), 0);
        chk("rst_sda_a", 32'(sda_oe_a), 0);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_done_a", 32'(done_a), 0);
        chk("rst_error_a", 32'(error_a), 0);
        chk("rst_idx_a", 32'(lut_index_a), 0);
        chk("rst_erridx_a", 32'(err_index_a), 0);

        // Walk 1: auto start, two entries then end marker.
        push_frame(8'h72, 8'h41, 8'h10, 8'h00, 3);
        push_frame(8'h72, 8'h98, 8'h03, 8'h00, 3);
        base = frames;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("auto_busy_a", 32'(busy_a), 1);
        wait_for(0, 6000, "walk1");
        drain("walk1");
        chk("walk1_frames", 32'(frames - base), 2);
        chk("walk1_done", 32'(done_a), 1);
        chk("walk1_busy", 32'(busy_a), 0);
        chk("walk1_error", 32'(error_a), 0);
        chk("walk1_bus", 32'({scl_oe_a, sda_oe_a}), 0);
        chk("noauto_busy_b", 32'(busy_b), 0);

        // Walk 2: 2-byte register address, SCL high time on divider 3.
        push_frame(8'h72, 8'h30, 8'h0A, 8'h5A, 4);
        pulse_b();
        wait_for(1, 6000, "walk2");
        drain("walk2");
        chk("walk2_scl_high", 32'(hi_len), 6);
        chk("walk2_done", 32'(done_b), 1);

        // Walk 3: data byte NACKed twice, then accepted.
        rom_a = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        nack_data_lim = data_nacks + 2;
        for (int i = 0; i < 3; i++) push_frame(8'h72, 8'h12, 8'h34, 8'h00, 3);
        base = frames;
        pulse_a();
        chk("restart_done_clr", 32'(done_a), 0);
        wait_for(0, 8000, "walk3");
        drain("walk3");
        chk("walk3_frames", 32'(frames - base), 3);
        chk("walk3_done", 32'(done_a), 1);
        chk("walk3_error", 32'(error_a), 0);

        // Walk 4: address of entry 2 always NACKed.
        rom_a = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        base = frames;
        nack_addr_thr = base + 3;
        push_frame(8'h72, 8'h01, 8'h01, 8'h00, 3);
        push_frame(8'h72, 8'h02, 8'h02, 8'h00, 3);
        for (int i = 0; i < 4; i++) push_frame(8'h72, 8'h00, 8'h00, 8'h00, 1);
        pulse_a();
        wait_for(0, 8000, "walk4");
        drain("walk4");
        nack_addr_thr = 1000000;
        chk("walk4_frames", 32'(frames - base), 6);
        chk("walk4_error", 32'(error_a), 1);
        chk("walk4_done", 32'(done_a), 0);
        chk("walk4_erridx", 32'(err_index_a), 2);
        repeat (50) @(posedge clk);
        #1;
        chk("walk4_idx_frozen", 32'(lut_index_a), 2);
        chk("walk4_bus", 32'({scl_oe_a, sda_oe_a, busy_a}), 0);

        // Walk 5: full table without end marker, start while busy ignored.
        rom_b = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        push_frame(8'h72, 8'h11, 8'h11, 8'h11, 4);
        push_frame(8'h72, 8'h22, 8'h22, 8'h22, 4);
        push_frame(8'h72, 8'h33, 8'h33, 8'h33, 4);
        push_frame(8'h72, 8'h44, 8'h44, 8'h44, 4);
        base = frames;
        frame_target = base + 2;
        pulse_b();
        wait_for(3, 4000, "walk5_mid");
        pulse_b();
        chk("walk5_busy", 32'(busy_b), 1);
        wait_for(1, 8000, "walk5");
        drain("walk5");
        chk("walk5_frames", 32'(frames - base), 4);
        chk("walk5_done", 32'(done_b), 1);
        chk("walk5_wrap_idx", 32'(lut_index_b), 0);

        // Walk 6: reset mid-SHIFT, auto restart from entry 0.
        rom_a = '{16'h4110, 16'h9803, 16'hFFFF, 16'hFFFF};
        base = frames;
        pulse_a();
        chk("restart_err_clr", 32'({error_a, err_index_a}), 0);
        wait_for(2, 2000, "walk6_mid");
        #1 rst_n_a = 1'b0;
        #1;
        chk("async_rst_bus", 32'({scl_oe_a, sda_oe_a}), 0);
        chk("async_rst_busy", 32'(busy_a), 0);
        push_frame(8'h72, 8'h41, 8'h10, 8'h00, 3);
        push_frame(8'h72, 8'h98, 8'h03, 8'h00, 3);
        repeat (5) @(posedge clk);
        #1 rst_n_a = 1'b1;
        wait_for(0, 6000, "walk6");
        drain("walk6");
        chk("walk6_frames", 32'(frames - base), 3);
        chk("walk6_done", 32'(done_a), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
